move_input: RTL and testbench

- Player-side input conditioner for the battle system; the input-direction counterpart of the HP/damage display path.
- Takes the raw active-low push-button and the 2-bit move-select switches and synchronizes them.
- Debounces the button press and hands exactly one move per press to the control FSM over a valid/ready handshake.
- Sits between board KEY/SW pins and the control FSM / datapath p_move input.

---
 rtl/battle_pkg.sv | 20 ++
 rtl/move_input_sync2.sv | 28 ++
 rtl/move_input.sv | 200 ++++++++++++++++++++
 tb/tb_move_input.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// rtl/battle_pkg.sv - shared battle-system types: move codes and move_input FSM states
package battle_pkg;

  localparam int MOVE_W_DEF = 2;

  typedef logic [MOVE_W_DEF-1:0] move_t;

  localparam move_t MOVE_0 = 2'd0;
  localparam move_t MOVE_1 = 2'd1;
  localparam move_t MOVE_2 = 2'd2;
  localparam move_t MOVE_3 = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DB_PRESS   = 2'd1,
    S_OFFER      = 2'd2,
    S_DB_RELEASE = 2'd3
  } move_state_t;

endpackage

// File: rtl/move_input_sync2.sv
// rtl/move_input_sync2.sv - sync2: two-flop synchronizer with configurable reset value
module sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/move_input.sv
// rtl/move_input.sv - debounced one-move-per-press player input with valid/ready output; optional turn timeout under TURN_TIMEOUT_EN
module move_input
  import battle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MOVE_W          = MOVE_W_DEF,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_n,
  input  logic [MOVE_W-1:0] move_sel,
  input  logic              enable,
  input  logic              move_ready,
  output logic              move_valid,
  output logic [MOVE_W-1:0] move_code,
  output logic              move_timeout,
  output logic              busy,
  output logic [7:0]        press_count
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              w_key_s;
  logic [MOVE_W-1:0] w_sel_s;
  logic              w_pressed;

  move_state_t       r_state;
  move_state_t       w_state_nx;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_db_done;
  logic              w_latch;
  logic              w_xfer;
  logic              w_to_fire;
  logic              w_to_done;
  logic              w_to_move;
  logic [MOVE_W-1:0] r_code;
  logic [7:0]        r_press_count;

  sync2 #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_key_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (key_n),
    .q       (w_key_s)
  );

  sync2 #(
    .WIDTH   (MOVE_W),
    .RST_VAL ('0)
  ) u_sel_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (move_sel),
    .q       (w_sel_s)
  );

  assign w_pressed = ~w_key_s;

  // saturating increment; the counter never needs to exceed DEBOUNCE_CYCLES
  assign w_cnt_inc = (r_cnt == DB_MAX) ? r_cnt : r_cnt + CNT_ONE;
  assign w_db_done = (w_cnt_inc == DB_MAX);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // next-state, debounce counter and datapath strobes
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_latch    = 1'b0;
    w_xfer     = 1'b0;
    w_to_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (w_pressed && enable) begin
          w_state_nx = S_DB_PRESS;
          w_cnt_nx   = CNT_ONE;
        end else if (enable && w_to_done) begin
          w_state_nx = S_OFFER;
          w_to_fire  = 1'b1;
        end
      end
      S_DB_PRESS: begin
        if (!w_pressed) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (w_db_done) begin
          w_state_nx = S_OFFER;
          w_cnt_nx   = '0;
          w_latch    = 1'b1;
        end else begin
          w_cnt_nx   = w_cnt_inc;
        end
      end
      S_OFFER: begin
        w_cnt_nx = '0;
        if (move_ready) begin
          w_xfer     = 1'b1;
          // a timeout move has no button to wait on, so skip release debounce
          w_state_nx = w_to_move ? S_IDLE : S_DB_RELEASE;
        end
      end
      S_DB_RELEASE: begin
        if (w_pressed) begin
          w_cnt_nx   = '0;
        end else if (w_db_done) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx   = w_cnt_inc;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // debounce counter, latched move code and transfer count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_code        <= '0;
      r_press_count <= 8'd0;
    end else begin
      r_cnt <= w_cnt_nx;
      if (w_latch) begin
        r_code <= w_sel_s;
      end else if (w_to_fire) begin
        r_code <= MOVE_W'(MOVE_0);
      end
      if (w_xfer) begin
        r_press_count <= r_press_count + 8'd1;
      end
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  assign w_to_done = (r_to_cnt == TO_LAST);

  // idle-with-enable cycle counter; any other condition restarts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (r_state == S_IDLE && enable && w_state_nx == S_IDLE) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  // marks the offered move as timeout-generated until it is taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout <= 1'b0;
    end else if (w_to_fire) begin
      r_timeout <= 1'b1;
    end else if (w_xfer) begin
      r_timeout <= 1'b0;
    end
  end

  assign w_to_move = r_timeout;
`else
  assign w_to_done = 1'b0;
  assign w_to_move = 1'b0;
`endif

  // outputs decoded from state so an async reset drops move_valid at once
  always_comb begin
    move_valid = (r_state == S_OFFER);
    busy       = (r_state != S_IDLE);
  end

  assign move_code    = r_code;
  assign move_timeout = w_to_move;
  assign press_count  = r_press_count;

endmodule

// File: tb/tb_move_input.sv
// tb/tb_move_input.sv - table-driven and directed bench for move_input (DEBOUNCE_CYCLES=4)
module tb_move_input;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_n;
  logic [1:0] move_sel;
  logic       enable;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_code;
  logic       move_timeout;
  logic       busy;
  logic [7:0] press_count;

  int n_tests = 0;
  int n_fail  = 0;

  move_input #(
    .DEBOUNCE_CYCLES (DEB),
    .MOVE_W          (2),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_n        (key_n),
    .move_sel     (move_sel),
    .enable       (enable),
    .move_ready   (move_ready),
    .move_valid   (move_valid),
    .move_code    (move_code),
    .move_timeout (move_timeout),
    .busy         (busy),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       key_n;
    logic [1:0] sel;
    logic       en;
    logic       rdy;
    logic       e_valid;
    logic [1:0] e_code;
    logic       e_busy;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic k, input logic [1:0] s, input logic en, input logic rdy,
                     input logic v, input logic [1:0] c, input logic b, input logic [7:0] n);
    vec_t t;
    t.key_n = k; t.sel = s; t.en = en; t.rdy = rdy;
    t.e_valid = v; t.e_code = c; t.e_busy = b; t.e_cnt = n;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    key_n = 1'b1; move_sel = 2'd0; enable = 1'b0; move_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(move_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_code", 32'(move_code), 32'd0);
    chk("rst_count", 32'(press_count), 32'd0);
    chk("rst_timeout", 32'(move_timeout), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  int seen;

  initial begin
    reset_n = 1'b0; key_n = 1'b1; move_sel = 2'd0; enable = 1'b0; move_ready = 1'b0;
    do_reset();

    // bounce: low 2, high 1, low 2, then high (row i = inputs before edge i, outputs after it)
    add(0,0,1,0, 0,0,0,0);
    add(0,0,1,0, 0,0,0,0);
    add(1,0,1,0, 0,0,1,0);
    add(0,0,1,0, 0,0,1,0);
    add(0,0,1,0, 0,0,0,0);
    add(1,0,1,0, 0,0,1,0);
    add(1,0,1,0, 0,0,1,0);
    add(1,0,1,0, 0,0,0,0);
    add(1,0,1,0, 0,0,0,0);
    // clean press, sel=2: valid after edge 6, ready on edge 8, release debounced by edge 14
    add(0,2,1,0, 0,0,0,0);
    add(0,2,1,0, 0,0,0,0);
    add(0,2,1,0, 0,0,1,0);
    add(0,2,1,0, 0,0,1,0);
    add(0,2,1,0, 0,0,1,0);
    add(0,2,1,0, 1,2,1,0);
    add(0,2,1,0, 1,2,1,0);
    add(0,2,1,1, 0,2,1,1);
    add(1,2,1,0, 0,2,1,1);
    add(1,2,1,0, 0,2,1,1);
    add(1,2,1,0, 0,2,1,1);
    add(1,2,1,0, 0,2,1,1);
    add(1,2,1,0, 0,2,1,1);
    add(1,2,1,0, 0,2,0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      key_n = vecs[i].key_n; move_sel = vecs[i].sel;
      enable = vecs[i].en;   move_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(move_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_code", i), 32'(move_code), 32'(vecs[i].e_code));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_count", i), 32'(press_count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_timeout", i), 32'(move_timeout), 32'd0);
    end

    // hold 50 cycles with ready high: one transfer; then release and press again
    do_reset();
    enable = 1'b1; move_ready = 1'b1; move_sel = 2'd1; key_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (move_valid) seen++;
    end
    chk("hold_one_xfer", 32'(seen), 32'd1);
    chk("hold_count", 32'(press_count), 32'd1);
    key_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("hold_rel_idle", 32'(busy), 32'd0);
    key_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (move_valid) seen++;
    end
    chk("hold_two_xfer", 32'(seen), 32'd2);
    chk("hold_count2", 32'(press_count), 32'd2);
    chk("hold_code", 32'(move_code), 32'd1);

    // press while disabled is ignored; raising enable with key held accepts after 4 samples
    do_reset();
    enable = 1'b0; move_sel = 2'd1; key_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (move_valid || busy) seen++;
    end
    chk("dis_ignored", 32'(seen), 32'd0);
    enable = 1'b1;
    step(); step(); step();
    chk("en_not_yet", 32'(move_valid), 32'd0);
    step();
    chk("en_valid", 32'(move_valid), 32'd1);
    chk("en_code", 32'(move_code), 32'd1);
    move_sel = 2'd3; enable = 1'b0; key_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("offer_hold_valid", 32'(move_valid), 32'd1);
    chk("offer_hold_code", 32'(move_code), 32'd1);
    move_ready = 1'b1;
    step();
    move_ready = 1'b0;
    chk("offer_xfer_valid", 32'(move_valid), 32'd0);
    chk("offer_xfer_count", 32'(press_count), 32'd1);

    // async reset while move_valid is high
    do_reset();
    enable = 1'b1; move_sel = 2'd3; key_n = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("pre_rst_valid", 32'(move_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(move_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_code", 32'(move_code), 32'd0);
    chk("async_count", 32'(press_count), 32'd0);
    step();
    key_n = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_count", 32'(press_count), 32'd0);
    chk("post_rst_valid", 32'(move_valid), 32'd0);

    // idle with enable and no press
    do_reset();
    enable = 1'b1; key_n = 1'b1; move_ready = 1'b0;
`ifdef TURN_TIMEOUT_EN
    seen = 0;
    for (int i = 0; i < 63; i++) begin
      step();
      if (move_valid) seen++;
    end
    chk("to_early", 32'(seen), 32'd0);
    step();
    chk("to_valid", 32'(move_valid), 32'd1);
    chk("to_flag", 32'(move_timeout), 32'd1);
    chk("to_code", 32'(move_code), 32'd0);
    move_ready = 1'b1;
    step();
    move_ready = 1'b0;
    chk("to_xfer_valid", 32'(move_valid), 32'd0);
    chk("to_xfer_flag", 32'(move_timeout), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_count", 32'(press_count), 32'd1);
`else
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (move_valid || move_timeout || busy) seen++;
    end
    chk("no_timeout", 32'(seen), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
